// File: rtl/sfifo_wm.sv
// sfifo_wm: synchronous FIFO with programmable almost-full/almost-empty
// watermarks, show-ahead or registered read data, flush, and overflow/underflow
// error reporting. Depth need not be a power of two.
module sfifo_wm #(
    parameter int  FIFO_D   = 12,
    parameter int  FIFO_W   = 32,
    parameter int  FIFO_DLY = 0,
    parameter int  AF_TH    = FIFO_D - 2,
    parameter int  AE_TH    = 2,
    localparam int FIFO_ADR = $clog2(FIFO_D)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fifo_we,
    input  logic [FIFO_W-1:0] fifo_wd,
    input  logic              fifo_re,
    input  logic              fifo_fsh,
    output logic [FIFO_W-1:0] fifo_rd,
    output logic              fifo_rvld,
    output logic [FIFO_ADR:0] fifo_len,
    output logic              fifo_full,
    output logic              fifo_empt,
    output logic              fifo_afull,
    output logic              fifo_aempt,
    output logic              fifo_ovf,
    output logic              fifo_udf,
    output logic [1:0]        fifo_err
);

    // Parameter legality is enforced at elaboration time.
    if (FIFO_D < 2) begin : g_bad_depth
        $error("sfifo_wm: FIFO_D must be >= 2");
    end
    if (AF_TH < 1 || AF_TH > FIFO_D) begin : g_bad_af
        $error("sfifo_wm: AF_TH must be in 1..FIFO_D");
    end
    if (AE_TH < 0 || AE_TH > FIFO_D - 1) begin : g_bad_ae
        $error("sfifo_wm: AE_TH must be in 0..FIFO_D-1");
    end
    if (FIFO_DLY != 0 && FIFO_DLY != 1) begin : g_bad_dly
        $error("sfifo_wm: FIFO_DLY must be 0 or 1");
    end

    localparam int LEN_W = FIFO_ADR + 1;
    localparam logic [FIFO_ADR:0]   LEN_MAX  = LEN_W'(FIFO_D);
    localparam logic [FIFO_ADR:0]   LEN_AF   = LEN_W'(AF_TH);
    localparam logic [FIFO_ADR:0]   LEN_AE   = LEN_W'(AE_TH);
    localparam logic [FIFO_ADR-1:0] PTR_LAST = FIFO_ADR'(FIFO_D - 1);

    logic [FIFO_W-1:0]   mem [FIFO_D];
    logic [FIFO_ADR-1:0] wptr;
    logic [FIFO_ADR-1:0] rptr;
    logic                push_ok;
    logic                pop_ok;

    // Pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [FIFO_ADR-1:0] next_ptr(input logic [FIFO_ADR-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Accept decisions: pop only when non-empty; push when not full, or when
    // full and a pop frees a slot in the same cycle.
    always_comb begin
        pop_ok  = fifo_re && (fifo_len != '0);
        push_ok = fifo_we && ((fifo_len != LEN_MAX) || pop_ok);
    end

    // Pointers and occupancy; flush zeroes them and ignores same-cycle requests.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_len <= '0;
        end else if (fifo_fsh) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_len <= '0;
        end else begin
            if (push_ok) wptr <= next_ptr(wptr);
            if (pop_ok)  rptr <= next_ptr(rptr);
            case ({push_ok, pop_ok})
                2'b10:   fifo_len <= fifo_len + 1'b1;
                2'b01:   fifo_len <= fifo_len - 1'b1;
                default: fifo_len <= fifo_len;
            endcase
        end
    end

    // Error pulses one cycle after a rejected request, plus sticky summary.
    always_ff @(posedge clk) begin
        if (!rstn || fifo_fsh) begin
            fifo_ovf <= 1'b0;
            fifo_udf <= 1'b0;
            fifo_err <= '0;
        end else begin
            fifo_ovf <= fifo_we && !push_ok;
            fifo_udf <= fifo_re && !pop_ok;
            fifo_err <= fifo_err | {fifo_re && !pop_ok, fifo_we && !push_ok};
        end
    end

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (rstn && !fifo_fsh && push_ok) begin
            mem[wptr] <= fifo_wd;
        end
    end

    // Status flags decoded from the registered occupancy.
    assign fifo_full  = (fifo_len == LEN_MAX);
    assign fifo_empt  = (fifo_len == '0);
    assign fifo_afull = (fifo_len >= LEN_AF);
    assign fifo_aempt = (fifo_len <= LEN_AE);

    if (FIFO_DLY == 0) begin : g_showahead
        // Head entry presented combinationally.
        assign fifo_rd   = mem[rptr];
        assign fifo_rvld = fifo_re && !fifo_empt;
    end else begin : g_registered
        // Head entry captured on an accepted pop; the read of mem[rptr]
        // happens before a same-cycle push at full can overwrite that slot.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                fifo_rd   <= '0;
                fifo_rvld <= 1'b0;
            end else if (fifo_fsh) begin
                fifo_rvld <= 1'b0;
            end else begin
                fifo_rvld <= pop_ok;
                if (pop_ok) fifo_rd <= mem[rptr];
            end
        end
    end

endmodule

// File: doc/sfifo_wm.md
SFIFO_WM -- requirements
Module: sfifo_wm

Interface
REQ-001 SHALL have parameter FIFO_D, default 12, depth in entries (>=2; non-power-of-two legal).
REQ-002 SHALL have parameter FIFO_W, default 32, data width in bits.
REQ-003 SHALL have parameter FIFO_DLY, default 0, read mode: 0 = show-ahead, 1 = registered read data.
REQ-004 SHALL have parameter AF_TH, default FIFO_D-2, almost-full threshold (1..FIFO_D).
REQ-005 SHALL have parameter AE_TH, default 2, almost-empty threshold (0..FIFO_D-1).
REQ-006 SHALL have local parameter FIFO_ADR = $clog2(FIFO_D), not overridable.
REQ-007 SHALL have one clock and a synchronous, active-low reset: clk  in  1  clock, rising edge; rstn  in  1  synchronous active-low reset.
REQ-008 SHALL have ports: fifo_we  in  1  push request; fifo_wd  in  FIFO_W  push data; fifo_re  in  1  pop request; fifo_fsh  in  1  flush.
REQ-009 SHALL have ports: fifo_rd  out  FIFO_W  read data; fifo_rvld  out  1  read data valid; fifo_len  out  FIFO_ADR+1  occupancy.
REQ-010 SHALL have ports: fifo_full, fifo_empt, fifo_afull, fifo_aempt  out  1 each  status flags.
REQ-011 SHALL have ports: fifo_ovf, fifo_udf  out  1 each  error pulses; fifo_err  out  2  sticky errors {udf_seen, ovf_seen}.

Function
REQ-012 Priority per cycle SHALL be flush > accepted push/pop; flush SHALL zero pointers and fifo_len, ignore same-cycle we/re, raise no ovf/udf and clear fifo_err.
REQ-013 Push SHALL be accepted when fifo_we=1 and (fifo_len<FIFO_D, or fifo_len=FIFO_D with an accepted pop in the same cycle).
REQ-014 Pop SHALL be accepted when fifo_re=1 and fifo_len>0; a pop at fifo_len=0 SHALL be rejected even when a push occurs in the same cycle.
REQ-015 Write and read pointers SHALL advance by 1 per accepted operation and wrap from FIFO_D-1 to 0.
REQ-016 fifo_len SHALL be registered: +1 on push only, -1 on pop only, unchanged on both or neither; range 0..FIFO_D.
REQ-017 Flags SHALL be decoded from the registered fifo_len: full = (len==FIFO_D), empt = (len==0), afull = (len>=AF_TH), aempt = (len<=AE_TH).
REQ-018 A rejected push SHALL produce a one-cycle fifo_ovf pulse in the following cycle and set fifo_err[0]; the data is dropped.
REQ-019 A rejected pop SHALL produce a one-cycle fifo_udf pulse in the following cycle and set fifo_err[1]; the read pointer is unchanged.
REQ-020 fifo_err bits SHALL hold until reset or flush.
REQ-021 FIFO_DLY=0: fifo_rd SHALL combinationally present the head entry, valid while fifo_empt=0; fifo_rvld = fifo_re & ~fifo_empt, same cycle.
REQ-022 FIFO_DLY=1: on an accepted pop, fifo_rd SHALL register the head entry and fifo_rvld SHALL pulse high in the next cycle; otherwise fifo_rd holds and fifo_rvld=0.
REQ-023 Data SHALL leave in exact write order; a push into the slot freed by a same-cycle pop at full SHALL not corrupt the popped data.
REQ-024 Invalid parameters (FIFO_D<2, AF_TH or AE_TH out of range, FIFO_DLY not 0/1) SHALL cause an elaboration error.

Reset
REQ-025 With rstn=0 at a rising clk edge: pointers=0, fifo_len=0, fifo_empt=1, fifo_aempt=1, fifo_full=0, fifo_afull=0, fifo_ovf=0, fifo_udf=0, fifo_err=0, fifo_rvld=0, fifo_rd=0 (FIFO_DLY=1).
REQ-026 Reset SHALL override flush, push and pop in the same cycle; storage contents SHALL not be reset.

Verification (FIFO_D=12, FIFO_W=32, AF_TH=10, AE_TH=2 unless stated)
REQ-027 rstn=0 for 3 cycles with fifo_we=1, wd=0xDEAD -> fifo_len=0, fifo_empt=1, no entry written, no ovf.
REQ-028 Push 0x1..0xC -> afull at len 10, full at len 12; 13th push 0xD -> fifo_ovf one cycle, fifo_err=2'b01, len stays 12; drain returns 0x1..0xC in order, empt at end.
REQ-029 At len 12, we=1 (0x55) and re=1 -> pop returns oldest, len stays 12, 0x55 is read last; at len 0, we=1 (0x77) and re=1 -> fifo_udf pulse, fifo_err[1]=1, len=1, next pop returns 0x77.
REQ-030 At len 7 with fifo_err=2'b11, assert fifo_fsh with we=1 and re=1 -> next cycle len=0, empt=1, aempt=1, fifo_err=0, no ovf/udf pulse.
REQ-031 FIFO_DLY=1: push 0xA5, then re=1 -> fifo_rvld=1 and fifo_rd=0xA5 exactly one cycle later; fifo_rd holds 0xA5 afterwards.
REQ-032 200 cycles of random we/re/fsh (fsh 2%) at both FIFO_DLY values and FIFO_D=12 and 16 -> every pop matches a reference queue; pointers wrap; flags and fifo_len track the model each cycle.
